// File: rtl/hub75_scan_ctrl_if.sv
// Column-word stream from the plane buffer into the HUB75 scan controller.
// The master presents {R1,G1,B1,R2,G2,B2}. A word moves on valid & ready.
interface hub75_scan_ctrl_if;
    logic       valid;
    logic [5:0] data;
    logic       ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/hub75_scan_ctrl.sv
// HUB75 refresh sequencer: shifts bit-plane columns into the panel, then latches them.
// OE is driven with binary-coded-modulation timing, overlapping the next plane's shift.
module hub75_scan_ctrl #(
    parameter int COLS       = 64,
    parameter int ROW_ADDR_W = 5,
    parameter int PLANES     = 8,
    parameter int BASE_OE    = 4
) (
    input  logic                        clk,
    input  logic                        areset,
    input  logic                        i_enable,
    hub75_scan_ctrl_if.slave            s_axi,
    output logic [ROW_ADDR_W-1:0]       o_row,
    output logic [$clog2(PLANES)-1:0]   o_plane,
    output logic                        o_frame_done,
    output logic                        hub75_clk,
    output logic [5:0]                  hub75_rgb,
    output logic                        hub75_lat,
    output logic                        hub75_oe_n,
    output logic [ROW_ADDR_W-1:0]       hub75_addr
);

    localparam int PW   = $clog2(PLANES);
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int OE_W = $clog2(BASE_OE << (PLANES - 1)) + 1;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        WAIT_OE,
        BLANK,
        LATCH
    } state_e;

    state_e                  state_q;
    logic [CW-1:0]           col_q;
    logic [PW-1:0]           plane_q;
    logic [ROW_ADDR_W-1:0]   row_q;
    logic [OE_W-1:0]         oe_cnt_q, oe_cnt_d;
    logic [5:0]              rgb_q;
    logic                    sclk_q;
    logic                    lat_q;
    logic                    done_q;
    logic [ROW_ADDR_W-1:0]   addr_q;

    logic col_last, plane_last, row_last, frame_end;

    assign col_last   = (col_q == CW'(COLS - 1));
    assign plane_last = (plane_q == PW'(PLANES - 1));
    assign row_last   = &row_q;
    assign frame_end  = plane_last && row_last;

    // The on-time counter runs in every state so a plane keeps its full weight
    // even when the block drops back to IDLE after the last latch of a frame.
    always_comb begin
        oe_cnt_d = oe_cnt_q;
        if (state_q == LATCH)
            oe_cnt_d = OE_W'(BASE_OE) << plane_q;
        else if (oe_cnt_q != '0)
            oe_cnt_d = oe_cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q  <= IDLE;
            col_q    <= '0;
            plane_q  <= '0;
            row_q    <= '0;
            oe_cnt_q <= '0;
            rgb_q    <= '0;
            sclk_q   <= 1'b0;
            lat_q    <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
        end else begin
            oe_cnt_q <= oe_cnt_d;
            sclk_q   <= 1'b0;
            lat_q    <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (i_enable) begin
                        state_q <= SHIFT_LO;
                        col_q   <= '0;
                        plane_q <= '0;
                        row_q   <= '0;
                    end
                end
                SHIFT_LO: begin
                    if (s_axi.valid) begin
                        rgb_q   <= s_axi.data;
                        sclk_q  <= 1'b1;
                        state_q <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (col_last) begin
                        col_q   <= '0;
                        state_q <= WAIT_OE;
                    end else begin
                        col_q   <= col_q + 1'b1;
                        state_q <= SHIFT_LO;
                    end
                end
                WAIT_OE: begin
                    if (oe_cnt_q == '0)
                        state_q <= BLANK;
                end
                // Row address moves on entry to LATCH so it only ever changes while dark.
                BLANK: begin
                    state_q <= LATCH;
                    lat_q   <= 1'b1;
                    addr_q  <= row_q;
                    done_q  <= frame_end;
                end
                LATCH: begin
                    plane_q <= plane_last ? '0 : plane_q + 1'b1;
                    if (plane_last)
                        row_q <= row_q + 1'b1;
                    state_q <= (frame_end && !i_enable) ? IDLE : SHIFT_LO;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_axi.ready  = (state_q == SHIFT_LO);
    assign o_row        = row_q;
    assign o_plane      = plane_q;
    assign o_frame_done = done_q;
    assign hub75_clk    = sclk_q;
    assign hub75_rgb    = rgb_q;
    assign hub75_lat    = lat_q;
    assign hub75_oe_n   = (oe_cnt_q == '0);
    assign hub75_addr   = addr_q;

endmodule
